nibble_scan_mux: RTL

- Parametrised N-channel registered nibble multiplexer with a built-in scan sequencer.
- Selects one WIDTH-bit field from a packed input bus, either from a manual select or by auto-scanning enabled channels at a prescaled rate.
- Drives a registered data output plus active-low one-hot channel enables.
- Sits between the per-digit value registers and the seven-segment decoder and digit anodes; it is the successor to the 2:1 nibble select.

---
 rtl/nibble_scan_mux.sv | 128 ++++++++++++
 1 files changed

// File: rtl/nibble_scan_mux.sv
`default_nettype none
// ============================================================================
// Module   : nibble_scan_mux
// Purpose  : N-channel registered field mux with manual select or prescaled
//            auto-scan over enabled channels; drives data and active-low enables.
// Revision : 1.0 - initial release
// ============================================================================
module nibble_scan_mux #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int DIV      = 100000,
    parameter int SELW     = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic                      mode,
    input  logic [SELW-1:0]           sel,
    input  logic                      hold,
    input  logic [CHANNELS-1:0]       en_mask,
    output logic [WIDTH-1:0]          y,
    output logic [SELW-1:0]           ch,
    output logic [CHANNELS-1:0]       an_n,
    output logic                      tick
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   c_cnt_last = CW'(DIV - 1);
    localparam logic [SELW:0]   c_channels = (SELW + 1)'(CHANNELS);

    logic [CW-1:0]       r_cnt;
    logic [SELW-1:0]     r_ch;
    logic [WIDTH-1:0]    r_y;
    logic [CHANNELS-1:0] r_an_n;
    logic                r_tick;

    logic [WIDTH-1:0]    w_field [CHANNELS];
    logic                w_sel_ok;
    logic [SELW:0]       w_idx;
    logic [SELW-1:0]     w_adv_ch;
    logic                w_found;
    logic [CW-1:0]       w_cnt_nxt;
    logic [SELW-1:0]     w_ch_nxt;
    logic                w_tick_nxt;
    logic                w_en;
    logic [WIDTH-1:0]    w_y_nxt;
    logic [CHANNELS-1:0] w_an_nxt;

    generate
        for (genvar k = 0; k < CHANNELS; k++) begin : g_field
            assign w_field[k] = din[k*WIDTH +: WIDTH];
        end
    endgenerate

    // With a power-of-two channel count every sel value is a real channel.
    generate
        if ((1 << SELW) == CHANNELS) begin : g_sel_full
            assign w_sel_ok = 1'b1;
        end else begin : g_sel_range
            assign w_sel_ok = ({1'b0, sel} < c_channels);
        end
    endgenerate

    // First enabled channel after r_ch, wrapping; stays put if none found.
    always_comb begin
        w_adv_ch = r_ch;
        w_found  = 1'b0;
        w_idx    = '0;
        for (int i = 1; i < CHANNELS; i++) begin
            w_idx = {1'b0, r_ch} + (SELW + 1)'(i);
            if (w_idx >= c_channels) begin
                w_idx = w_idx - c_channels;
            end
            if (!w_found && en_mask[w_idx[SELW-1:0]]) begin
                w_adv_ch = w_idx[SELW-1:0];
                w_found  = 1'b1;
            end
        end
    end

    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_ch_nxt   = r_ch;
        w_tick_nxt = 1'b0;
        if (!mode) begin
            w_cnt_nxt = '0;
            if (w_sel_ok) begin
                w_ch_nxt = sel;
            end
        end else if (!hold) begin
            if (r_cnt == c_cnt_last) begin
                w_cnt_nxt  = '0;
                w_tick_nxt = 1'b1;
                w_ch_nxt   = w_adv_ch;
            end else begin
                w_cnt_nxt = r_cnt + CW'(1);
            end
        end
        w_en    = en_mask[w_ch_nxt];
        w_y_nxt = w_en ? w_field[w_ch_nxt] : '0;
        for (int k = 0; k < CHANNELS; k++) begin
            w_an_nxt[k] = ~(w_en && (w_ch_nxt == SELW'(k)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_ch   <= '0;
            r_y    <= '0;
            r_an_n <= '1;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_ch   <= w_ch_nxt;
            r_y    <= w_y_nxt;
            r_an_n <= w_an_nxt;
            r_tick <= w_tick_nxt;
        end
    end

    assign y    = r_y;
    assign ch   = r_ch;
    assign an_n = r_an_n;
    assign tick = r_tick;

endmodule
`default_nettype wire
